sort_cnt_ctrl: RTL and testbench
================================

# sort_cnt_ctrl

Sequencer for the banked counting memory of the sort engine. It clears every counter bank, then accepts a valid/ready stream of keys and issues one read-modify-write increment per key. Key-to-address/bank splitting is delegated to the address-generation unit; same-address hazards are resolved by forwarding. It sits between the key ingress stream and the counter SRAM banks, ahead of the prefix/scatter phase.

## Interface
- SORT_FUC_MAX_NUM, 1024, key range; number of counters
- SORT_FUC_BK_NUM, 4, counter banks
- SORT_FUC_CNT_MEM_DEPTH, MAX_NUM/BK_NUM (256), words per bank
- SORT_FUC_DATA_W, clog2(MAX_NUM) (10), key width
- SORT_FUC_CNT_W, clog2(MAX_NUM)+1 (11), counter width
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous assert, active-low
- start_i  in  1  start pulse; honoured only in IDLE
- data_vld_i  in  1  key valid
- data_i  in  DATA_W  key
- data_last_i  in  1  marks final key; qualified by a handshake
- data_rdy_o  out  1  ready for a key
- cnt_rd_en_o  out  1  bank read enable
- cnt_rd_addr_o  out  clog2(DEPTH)  read word address
- cnt_rd_bankid_o  out  clog2(BK_NUM)  read bank
- cnt_rd_data_i  in  CNT_W  read data, valid 1 cycle after cnt_rd_en_o
- cnt_wr_en_o  out  1  write enable
- cnt_wr_all_o  out  1  broadcast write to every bank (clear)
- cnt_wr_addr_o  out  clog2(DEPTH)  write address
- cnt_wr_bankid_o  out  clog2(BK_NUM)  write bank; ignored when cnt_wr_all_o is high
- cnt_wr_data_o  out  CNT_W  write data
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when counting completes

## Operation
- FSM IDLE -> CLEAR -> COUNT -> DRAIN -> IDLE.
- IDLE: start_i moves to CLEAR. start_i in any other state is ignored.
- CLEAR: clear pointer runs 0..DEPTH-1, one word per cycle. Each cycle drives cnt_wr_en_o=1, cnt_wr_all_o=1, data 0. After the last word, move to COUNT.
- COUNT: data_rdy_o=1 except during a stall (see Configuration).
  - Stage S0 (handshake cycle): read issued at the AGU addr/bank for the key.
  - Stage S1 (next cycle): write the same addr/bank with base+1, saturating at 2^CNT_W-1.
  - Base is cnt_rd_data_i, or the forwarded S1 write value when the S0 key matched S1 addr/bank in the previous cycle.
  - A handshake with data_last_i=1 moves to DRAIN.
- DRAIN: no handshakes. Wait until S1 is empty, pulse done_o, return to IDLE.
- Simultaneous S1 write and S0 read to the same word: the memory returns the old value; forwarding supplies the correct base.
- Reset mid-operation: returns to IDLE and kills the pipeline. Memory contents are undefined; the next start re-clears.

## Timing
- Reset values: all outputs 0, state IDLE, S1 valid 0.
- CLEAR length: exactly DEPTH cycles. data_rdy_o rises the cycle after the last clear write.
- Increment latency: a key handshaken in cycle n is written in cycle n+1.
- Throughput: 1 key/cycle, including back-to-back identical keys with forwarding enabled.
- done_o: asserted 2 cycles after the last handshake (S1 write at +1, pulse at +2). busy_o falls with the return to IDLE.

## Configuration
- SORT_CNT_FWD_EN defined: S1-to-S0 forwarding as described; no stalls.
- Undefined: no forwarding path.
  - When the incoming key's addr/bank equals the valid S1 addr/bank, data_rdy_o is deasserted for that cycle.
  - The key is accepted the next cycle.
  - Repeated keys run at 1 key per 2 cycles.

## Structure
- Shared package sort_pkg holds:
  - state enum {IDLE, CLEAR, COUNT, DRAIN}
  - width constants SORT_FUC_CNT_W and the derived address/bank widths
  - counter saturation constant
- One sub-module: an instance of SORT_AGU for the key -> cnt addr/bankid split. Its sbu outputs are left unconnected.

## Test plan
- Reset then start_i: 256 writes with cnt_wr_all_o=1, addresses 0..255, data 0; data_rdy_o rises on cycle 257.
- Keys 5, 6, 7 (last on 7): writes of 1 at bank 1/addr 1, bank 2/addr 1, bank 3/addr 1; done_o two cycles after key 7.
- Key 9 sent 4× back-to-back: writes of 1, 2, 3, 4 to bank 1/addr 2.
  - With SORT_CNT_FWD_EN: consecutive cycles.
  - Without: data_rdy_o low every other cycle.
- Preloaded counter 2047, key hits it: write data stays 2047.
- start_i during COUNT is ignored. rst_n_i low mid-COUNT: all outputs 0 asynchronously, state IDLE.
- data_vld_i held during CLEAR: no handshake and no rd_en until COUNT.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and sizing for the sort engine counting phase.
package sort_pkg;

    localparam int unsigned SORT_FUC_MAX_NUM       = 1024;
    localparam int unsigned SORT_FUC_BK_NUM        = 4;
    localparam int unsigned SORT_FUC_CNT_MEM_DEPTH = SORT_FUC_MAX_NUM / SORT_FUC_BK_NUM;
    localparam int unsigned SORT_FUC_DATA_W        = $clog2(SORT_FUC_MAX_NUM);
    localparam int unsigned SORT_FUC_CNT_W         = $clog2(SORT_FUC_MAX_NUM) + 1;
    localparam int unsigned SORT_FUC_ADDR_W        = $clog2(SORT_FUC_CNT_MEM_DEPTH);
    localparam int unsigned SORT_FUC_BK_W          = $clog2(SORT_FUC_BK_NUM);

    localparam logic [SORT_FUC_CNT_W-1:0] SORT_FUC_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Location of one counter word in the banked memory.
    typedef struct packed {
        logic [SORT_FUC_ADDR_W-1:0] addr;
        logic [SORT_FUC_BK_W-1:0]   bankid;
    } cnt_loc_t;

    function automatic logic [SORT_FUC_CNT_W-1:0] sat_inc(input logic [SORT_FUC_CNT_W-1:0] v);
        return (v == SORT_FUC_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sort_agu.sv
// Address generation: splits a key into counter bank/word and scatter-buffer bank/word.
module sort_agu
    import sort_pkg::*;
(
    input  logic [SORT_FUC_DATA_W-1:0] key,
    output cnt_loc_t                   cnt_loc_c,
    output logic [SORT_FUC_ADDR_W-1:0] sbu_addr_c,
    output logic [SORT_FUC_BK_W-1:0]   sbu_bankid_c
);

    // Counters interleave on key LSBs so neighbouring keys land in different banks.
    assign cnt_loc_c.bankid = key[SORT_FUC_BK_W-1:0];
    assign cnt_loc_c.addr   = key[SORT_FUC_DATA_W-1:SORT_FUC_BK_W];

    assign sbu_bankid_c = key[SORT_FUC_DATA_W-1 -: SORT_FUC_BK_W];
    assign sbu_addr_c   = key[SORT_FUC_ADDR_W-1:0];

endmodule

// File: rtl/sort_cnt_ctrl.sv
// Counting-memory sequencer: clears all banks, then read-modify-write increments one counter per key.
// Define SORT_CNT_FWD_EN for S1->S0 forwarding; otherwise same-word keys stall one cycle.
module sort_cnt_ctrl
    import sort_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic                       data_vld_i,
    input  logic [SORT_FUC_DATA_W-1:0] data_i,
    input  logic                       data_last_i,
    output logic                       data_rdy_o,
    output logic                       cnt_rd_en_o,
    output logic [SORT_FUC_ADDR_W-1:0] cnt_rd_addr_o,
    output logic [SORT_FUC_BK_W-1:0]   cnt_rd_bankid_o,
    input  logic [SORT_FUC_CNT_W-1:0]  cnt_rd_data_i,
    output logic                       cnt_wr_en_o,
    output logic                       cnt_wr_all_o,
    output logic [SORT_FUC_ADDR_W-1:0] cnt_wr_addr_o,
    output logic [SORT_FUC_BK_W-1:0]   cnt_wr_bankid_o,
    output logic [SORT_FUC_CNT_W-1:0]  cnt_wr_data_o,
    output logic                       busy_o,
    output logic                       done_o
);

    state_e                     state_q, state_nxt;
    logic [SORT_FUC_ADDR_W-1:0] clr_ptr_q, clr_ptr_nxt;
    logic                       s1_vld_q, s1_vld_nxt;
    cnt_loc_t                   s1_loc_q, s1_loc_nxt;
    logic                       busy_q, busy_nxt;
    logic                       done_q, done_nxt;

    cnt_loc_t                   key_loc;
    logic                       hit_c, stall_c, rdy_c, hs_c;
    logic [SORT_FUC_CNT_W-1:0]  base_c, wr_val_c;

    sort_agu u_agu (
        .key          (data_i),
        .cnt_loc_c    (key_loc),
        .sbu_addr_c   (),
        .sbu_bankid_c ()
    );

    assign hit_c    = s1_vld_q && (key_loc == s1_loc_q);
    assign rdy_c    = (state_q == COUNT) && !stall_c;
    assign hs_c     = data_vld_i && rdy_c;
    assign wr_val_c = sat_inc(base_c);

`ifdef SORT_CNT_FWD_EN
    logic                      fwd_q;
    logic [SORT_FUC_CNT_W-1:0] fwd_val_q;

    // The memory returns the pre-write value for a same-cycle hit, so carry the S1 result forward.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fwd_q     <= 1'b0;
            fwd_val_q <= '0;
        end else begin
            fwd_q     <= hs_c && hit_c;
            fwd_val_q <= wr_val_c;
        end
    end

    assign stall_c = 1'b0;
    assign base_c  = fwd_q ? fwd_val_q : cnt_rd_data_i;
`else
    assign stall_c = hit_c;
    assign base_c  = cnt_rd_data_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_loc_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            clr_ptr_q <= clr_ptr_nxt;
            s1_vld_q  <= s1_vld_nxt;
            s1_loc_q  <= s1_loc_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        clr_ptr_nxt = '0;
        s1_vld_nxt  = hs_c;
        s1_loc_nxt  = hs_c ? key_loc : s1_loc_q;
        done_nxt    = 1'b0;
        busy_nxt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_ptr_q == SORT_FUC_ADDR_W'(SORT_FUC_CNT_MEM_DEPTH - 1)) begin
                    state_nxt = COUNT;
                end else begin
                    clr_ptr_nxt = clr_ptr_q + 1'b1;
                end
            end
            COUNT: begin
                if (hs_c && data_last_i) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // No keys enter here, so S1 retires this cycle.
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign data_rdy_o      = rdy_c;
    assign cnt_rd_en_o     = hs_c;
    assign cnt_rd_addr_o   = hs_c ? key_loc.addr : '0;
    assign cnt_rd_bankid_o = hs_c ? key_loc.bankid : '0;

    assign cnt_wr_en_o     = (state_q == CLEAR) || s1_vld_q;
    assign cnt_wr_all_o    = (state_q == CLEAR);
    assign cnt_wr_addr_o   = (state_q == CLEAR) ? clr_ptr_q : (s1_vld_q ? s1_loc_q.addr : '0);
    assign cnt_wr_bankid_o = s1_vld_q ? s1_loc_q.bankid : '0;
    assign cnt_wr_data_o   = s1_vld_q ? wr_val_c : '0;

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_sort_cnt_ctrl.sv
// Scoreboard bench for sort_cnt_ctrl with a behavioural banked counter memory.
module tb_sort_cnt_ctrl;
    import sort_pkg::*;

    localparam int DW   = int'(SORT_FUC_DATA_W);
    localparam int CW   = int'(SORT_FUC_CNT_W);
    localparam int BK   = 4;
    localparam int DEP  = 256;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start, data_vld, data_last, data_rdy;
    logic [SORT_FUC_DATA_W-1:0] data;
    logic rd_en, wr_en, wr_all, busy, done;
    logic [SORT_FUC_ADDR_W-1:0] rd_addr, wr_addr;
    logic [SORT_FUC_BK_W-1:0]   rd_bank, wr_bank;
    logic [SORT_FUC_CNT_W-1:0]  rd_q, wr_data;

    logic pl_req;
    logic [SORT_FUC_BK_W-1:0]   pl_bank;
    logic [SORT_FUC_ADDR_W-1:0] pl_addr;

    typedef struct {
        int bank;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   counts[SORT_FUC_MAX_NUM];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   clr_cnt = 0;
    int   clr_base = 0;
    bit   clr_open = 1'b0;

    logic [CW-1:0] mem [BK][DEP];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sort_cnt_ctrl dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .start_i         (start),
        .data_vld_i      (data_vld),
        .data_i          (data),
        .data_last_i     (data_last),
        .data_rdy_o      (data_rdy),
        .cnt_rd_en_o     (rd_en),
        .cnt_rd_addr_o   (rd_addr),
        .cnt_rd_bankid_o (rd_bank),
        .cnt_rd_data_i   (rd_q),
        .cnt_wr_en_o     (wr_en),
        .cnt_wr_all_o    (wr_all),
        .cnt_wr_addr_o   (wr_addr),
        .cnt_wr_bankid_o (wr_bank),
        .cnt_wr_data_o   (wr_data),
        .busy_o          (busy),
        .done_o          (done)
    );

    // Counter SRAM: registered read returning the pre-write value on collisions.
    always @(posedge clk) begin
        if (rd_en) rd_q <= mem[rd_bank][rd_addr];
        if (pl_req) mem[pl_bank][pl_addr] <= CW'(CMAX);
        if (wr_en) begin
            if (wr_all) begin
                for (int b = 0; b < BK; b++) mem[b][wr_addr] <= wr_data;
            end else begin
                mem[wr_bank][wr_addr] <= wr_data;
            end
        end
    end

    function automatic void chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Monitor: every write presented by the DUT is checked against the scoreboard.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (wr_all) begin
                chk("clr_expected", int'(clr_open), 1);
                chk("clr_addr", int'(wr_addr), clr_cnt - clr_base);
                chk("clr_data", int'(wr_data), 0);
                clr_cnt <= clr_cnt + 1;
            end else if (exp_q.size() == 0) begin
                chk("unexpected_wr", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_bank", int'(wr_bank), e.bank);
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
                chk("wr_latency", cyc, e.cyc);
            end
        end
    end

    function automatic int outs_active();
        return int'(|{data_rdy, rd_en, rd_addr, rd_bank, wr_en, wr_all,
                      wr_addr, wr_bank, wr_data, busy, done});
    endfunction

    task automatic do_start(input bit hold_vld);
        int s0;
        bit seen;
        for (int i = 0; i < int'(SORT_FUC_MAX_NUM); i++) counts[i] = 0;
        clr_base = clr_cnt;
        clr_open = 1'b1;
        start = 1'b1;
        if (hold_vld) begin
            data_vld = 1'b1;
            data     = DW'(5);
        end
        @(negedge clk);
        s0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (data_rdy) begin
                seen = 1'b1;
                break;
            end
            if (hold_vld) chk("rd_en_in_clear", int'(rd_en), 0);
        end
        data_vld = 1'b0;
        clr_open = 1'b0;
        chk("rdy_rise_seen", int'(seen), 1);
        chk("rdy_rise_cycle", cyc - s0, DEP + 1);
        chk("clr_words", clr_cnt - clr_base, DEP);
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input int k, input bit last, output int hs_cyc);
        bit ok = 1'b0;
        data_vld  = 1'b1;
        data      = DW'(k);
        data_last = last;
        hs_cyc    = -1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (data_rdy) begin
                ok     = 1'b1;
                hs_cyc = cyc;
                chk("rd_en", int'(rd_en), 1);
                chk("rd_bank", int'(rd_bank), k % BK);
                chk("rd_addr", int'(rd_addr), k / BK);
                counts[k] = (counts[k] >= CMAX) ? CMAX : counts[k] + 1;
                exp_q.push_back('{k % BK, k / BK, counts[k], cyc + 1});
                break;
            end
        end
        chk("key_accepted", int'(ok), 1);
        @(posedge clk);
        #1;
        data_vld  = 1'b0;
        data_last = 1'b0;
    endtask

    task automatic wait_done(input int last_hs);
        bit seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", cyc - last_hs, 2);
                chk("busy_at_done", int'(busy), 0);
                break;
            end
        end
        chk("done_seen", int'(seen), 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int hs[4];
        int gap;
        int k;
        start = 1'b0; data_vld = 1'b0; data = '0; data_last = 1'b0;
        pl_req = 1'b0; pl_bank = '0; pl_addr = '0;

        #3 rst_n = 1'b0;
        #1 chk("reset_outs", outs_active(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Clear with a key already waiting, then three keys in distinct banks.
        do_start(1'b1);
        send_key(5, 1'b0, h);
        send_key(6, 1'b0, h);
        send_key(7, 1'b1, h);
        wait_done(h);

        // Repeated key exercises the same-word hazard.
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send_key(9, i == 3, hs[i]);
`ifdef SORT_CNT_FWD_EN
        gap = 1;
`else
        gap = 2;
`endif
        for (int i = 1; i < 4; i++) chk("key9_gap", hs[i] - hs[i-1], gap);
        wait_done(hs[3]);

        // Saturation, plus a start pulse during COUNT that must be ignored.
        do_start(1'b0);
        pl_bank = SORT_FUC_BK_W'(13 % BK);
        pl_addr = SORT_FUC_ADDR_W'(13 / BK);
        pl_req  = 1'b1;
        @(posedge clk);
        #1 pl_req = 1'b0;
        counts[13] = CMAX;
        send_key(13, 1'b0, h);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_ignored_rdy", int'(data_rdy), 1);
        chk("start_ignored_busy", int'(busy), 1);
        chk("start_ignored_clr", int'(wr_all), 0);
        @(posedge clk);
        #1;
        send_key(13, 1'b1, h);
        wait_done(h);

        // Asynchronous reset while a write is in flight.
        do_start(1'b0);
        send_key(1, 1'b0, h);
        send_key(2, 1'b0, h);
        rst_n = 1'b0;
        #1 chk("midrun_reset_outs", outs_active(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_rdy", int'(data_rdy), 0);
        @(posedge clk);
        #1;

        // Random traffic concentrated on a few keys for frequent hazards.
        do_start(1'b0);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, 1023));
            else k = int'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                data_vld = 1'b0;
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
            send_key(k, i == 299, h);
        end
        wait_done(h);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
